// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order register write-back queue with read-port bypass
// Define WBQ_BYPASS_EN to build the a1/a2 forwarding comparators; otherwise hit/byp are tied to 0.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  input  logic                   drain_en,
  output logic                   we3,
  output logic [AW-1:0]          a3,
  output logic [DW-1:0]          wd3,
  input  logic [AW-1:0]          a1,
  input  logic [AW-1:0]          a2,
  output logic                   hit1,
  output logic                   hit2,
  output logic [DW-1:0]          byp1,
  output logic [DW-1:0]          byp2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && !empty;
  assign we3      = pop;
  // Popped slots keep stale contents, so the head is masked once the queue is empty.
  assign a3       = empty ? '0 : addr_q[rd_ptr_q];
  assign wd3      = empty ? '0 : data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= in_addr;
        data_q[wr_ptr_q] <= in_data;
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PW-1:0] idx;

  // Scan oldest to newest so the youngest matching entry wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == a1) begin
          hit1 = 1'b1;
          byp1 = data_q[idx];
        end
        if (addr_q[idx] == a2) begin
          hit2 = 1'b1;
          byp2 = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_bypass_inputs;

  assign unused_bypass_inputs = ^{a1, a2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign byp1 = '0;
  assign byp2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue against a queue-based reference model
// Bypass expectations follow WBQ_BYPASS_EN so both builds are checked.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] a1, a2;
  logic          hit1, hit2;
  logic [DW-1:0] byp1, byp2;
  logic [2:0]    count;
  logic          full, empty;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mdl[$];
  ent_t exp_q[$];
  logic do_push = 1'b0;
  logic do_pop  = 1'b0;
  ent_t push_ent;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .we3(we3), .a3(a3), .wd3(wd3),
    .a1(a1), .a2(a2), .hit1(hit1), .hit2(hit2), .byp1(byp1), .byp2(byp2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / checker: inputs are stable at the falling edge.
  always @(negedge clk) begin
    int   n;
    ent_t e;
    logic eh1, eh2;
    logic [DW-1:0] eb1, eb2;
    if (reset) begin
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_we3", we3, 0);
      chk("rst_a3", a3, 0);
      chk("rst_wd3", wd3, 0);
      chk("rst_hit", {hit1, hit2}, 0);
      chk("rst_byp", {byp1, byp2}, 0);
      do_push = 1'b0;
      do_pop  = 1'b0;
    end else begin
      n = mdl.size();
      chk("count", count, n);
      chk("full", full, n == DEPTH);
      chk("empty", empty, n == 0);
      chk("in_ready", in_ready, n < DEPTH);
      chk("we3", we3, drain_en && n > 0);
      if (we3) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("a3", a3, e.addr);
          chk("wd3", wd3, e.data);
        end
      end else if (n > 0) begin
        chk("a3_hold", a3, mdl[0].addr);
        chk("wd3_hold", wd3, mdl[0].data);
      end else begin
        chk("a3_idle", a3, 0);
        chk("wd3_idle", wd3, 0);
      end
      eh1 = 1'b0; eh2 = 1'b0; eb1 = '0; eb2 = '0;
`ifdef WBQ_BYPASS_EN
      foreach (mdl[i]) begin
        if (mdl[i].addr == a1) begin eh1 = 1'b1; eb1 = mdl[i].data; end
        if (mdl[i].addr == a2) begin eh2 = 1'b1; eb2 = mdl[i].data; end
      end
`endif
      chk("hit1", hit1, eh1);
      chk("byp1", byp1, eb1);
      chk("hit2", hit2, eh2);
      chk("byp2", byp2, eb2);
      do_pop   = drain_en && n > 0;
      do_push  = in_valid && n < DEPTH;
      push_ent = '{addr: in_addr, data: in_data};
    end
  end

  // Reference model state advances on the rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (do_pop && mdl.size() > 0) void'(mdl.pop_front());
      if (do_push) begin
        mdl.push_back(push_ent);
        exp_q.push_back(push_ent);
      end
    end
    do_pop  = 1'b0;
    do_push = 1'b0;
  end

  // Present inputs for one full cycle, returning at rising edge + 1.
  task automatic drive(input logic v, input int ad, input int dt, input logic dr,
                       input int r1, input int r2);
    in_valid = v;
    in_addr  = AW'(ad);
    in_data  = DW'(dt);
    drain_en = dr;
    a1       = AW'(r1);
    a2       = AW'(r2);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    drain_en = 1'b1;
    #1;
    reset = 1'b1;
    mdl.delete();
    exp_q.delete();
    #1;
    chk("async_count", count, 0);
    chk("async_we3", we3, 0);
    #4;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   drain_pct;
    reset = 1'b1;
    in_valid = 1'b0; in_addr = '0; in_data = '0; drain_en = 1'b0; a1 = '0; a2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write with latency one cycle.
    drive(1, 9, 'h6, 1, 9, 0);
    drive(0, 0, 0, 1, 9, 0);
    drive(0, 0, 0, 1, 9, 0);

    // Fill, hold the fifth request, then drain in order.
    for (int i = 0; i < 4; i++) drive(1, i + 1, 'h10 + i, 0, i + 1, 2);
    drive(1, 5, 'h14, 0, 1, 4);
    drive(1, 5, 'h14, 0, 3, 4);
    drive(1, 5, 'h14, 1, 5, 4);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 5, 1);

    // Two pending writes to one register, newest forwarded.
    drive(1, 14, 'h9, 0, 14, 3);
    drive(1, 14, 'hA, 0, 14, 3);
    drive(0, 0, 0, 0, 14, 3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 14, 3);

    // Push and pop together at count 1.
    drive(1, 6, 'h66, 0, 6, 7);
    drive(1, 7, 'h77, 1, 6, 7);
    drive(0, 0, 0, 0, 7, 6);
    drive(0, 0, 0, 1, 7, 6);

    // Reset with three entries pending.
    for (int i = 0; i < 3; i++) drive(1, 10 + i, 'h100 + i, 0, 10, 11);
    pulse_reset();
    drive(1, 12, 'h55, 1, 10, 12);
    drive(0, 0, 0, 1, 10, 12);
    drive(0, 0, 0, 0, 10, 12);

    // Randomised traffic; upstream holds a request until it is accepted.
    drain_pct = 50;
    in_valid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) drain_pct = $urandom_range(10, 90);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
        in_data  = $urandom;
      end
      drain_en = ($urandom_range(0, 99) < drain_pct);
      a1 = AW'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    end

    for (int i = 0; i < DEPTH + 3; i++) drive(0, 0, 0, 1, 0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
